// File: rtl/raster_extents_pipe.sv
// Two-stage pipelined raster edge-extents unit: per edge, sums the non-negative
// x/y coefficients scaled by a clamped tile log-size, with overflow detection.
module raster_extents_pipe #(
  parameter int  DATA_BITS        = 32,
  parameter int  NUM_EDGES        = 3,
  parameter int  MAX_TILE_LOGSIZE = 8,
  parameter int  TAG_WIDTH        = 8,
  parameter bit  SATURATE         = 1'b1,
  localparam int LS_BITS          = $clog2(MAX_TILE_LOGSIZE + 1)
) (
  input  logic                             clk,
  input  logic                             reset_n,
  input  logic                             valid_in,
  output logic                             ready_in,
  input  logic [NUM_EDGES*3*DATA_BITS-1:0] edges_in,
  input  logic [LS_BITS-1:0]               tile_logsize_in,
  input  logic [TAG_WIDTH-1:0]             tag_in,
  output logic                             valid_out,
  input  logic                             ready_out,
  output logic [NUM_EDGES*DATA_BITS-1:0]   extents_out,
  output logic [NUM_EDGES-1:0]             overflow_out,
  output logic [TAG_WIDTH-1:0]             tag_out
);

  localparam int WIDE = DATA_BITS + MAX_TILE_LOGSIZE;
  localparam logic [DATA_BITS-1:0] MAX_POS = {1'b0, {(DATA_BITS-1){1'b1}}};

  // Returns {shift_overflow, scaled}; negative coefficients contribute nothing.
  function automatic logic [DATA_BITS:0] scale(input logic [DATA_BITS-1:0] coef,
                                               input logic [LS_BITS-1:0]   sh);
    logic [WIDE-1:0] w;
    if (coef[DATA_BITS-1]) return '0;
    w = WIDE'(coef) << sh;
    return {|w[WIDE-1:DATA_BITS-1], w[DATA_BITS-1:0]};
  endfunction

  logic en1, en2;
  logic valid_s1, valid_s2;

  logic [LS_BITS-1:0]                      s_clamped;
  logic [NUM_EDGES-1:0][DATA_BITS-1:0]     ta_c, tb_c, ta_s1, tb_s1;
  logic [NUM_EDGES-1:0]                    shov_c, shov_s1;
  logic [TAG_WIDTH-1:0]                    tag_s1, tag_s2;
  logic [NUM_EDGES-1:0][DATA_BITS-1:0]     sum_c, ext_c, ext_s2;
  logic [NUM_EDGES-1:0]                    ovf_c, ovf_s2;
  logic                                    unused_c_bits;

  assign en2      = ~valid_s2 | ready_out;
  assign en1      = ~valid_s1 | en2;
  assign ready_in = en1;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through it can leave a value unassigned and infer a latch.
    s_clamped     = tile_logsize_in;
    ta_c          = '0;
    tb_c          = '0;
    shov_c        = '0;
    unused_c_bits = 1'b0;
    if (tile_logsize_in > LS_BITS'(MAX_TILE_LOGSIZE))
      s_clamped = LS_BITS'(MAX_TILE_LOGSIZE);
    for (int e = 0; e < NUM_EDGES; e++) begin
      logic [DATA_BITS:0] sa, sb;
      sa = scale(edges_in[(e*3+0)*DATA_BITS +: DATA_BITS], s_clamped);
      sb = scale(edges_in[(e*3+1)*DATA_BITS +: DATA_BITS], s_clamped);
      ta_c[e]   = sa[DATA_BITS-1:0];
      tb_c[e]   = sb[DATA_BITS-1:0];
      shov_c[e] = sa[DATA_BITS] | sb[DATA_BITS];
      // The c coefficient only rides along for interface compatibility.
      unused_c_bits ^= ^edges_in[(e*3+2)*DATA_BITS +: DATA_BITS];
    end
  end

  // With no shift overflow both terms are below 2^(DATA_BITS-1), so the sum's
  // top bit is set exactly when it exceeds the largest positive extent.
  always_comb begin
    sum_c = '0;
    ext_c = '0;
    ovf_c = '0;
    for (int e = 0; e < NUM_EDGES; e++) begin
      sum_c[e] = ta_s1[e] + tb_s1[e];
      ovf_c[e] = shov_s1[e] | sum_c[e][DATA_BITS-1];
      ext_c[e] = (SATURATE && ovf_c[e]) ? MAX_POS : sum_c[e];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process evaluation order.
    if (!reset_n) begin
      valid_s1 <= 1'b0;
      valid_s2 <= 1'b0;
    end else begin
      if (en1) valid_s1 <= valid_in;
      if (en2) valid_s2 <= valid_s1;
    end
  end

  // NOTE: data registers are reset too, because the outputs are driven straight
  // from stage 2 and must read zero after reset, not stale pipeline contents.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ta_s1   <= '0;
      tb_s1   <= '0;
      shov_s1 <= '0;
      tag_s1  <= '0;
    end else if (en1 && valid_in) begin
      ta_s1   <= ta_c;
      tb_s1   <= tb_c;
      shov_s1 <= shov_c;
      tag_s1  <= tag_in;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ext_s2 <= '0;
      ovf_s2 <= '0;
      tag_s2 <= '0;
    end else if (en2 && valid_s1) begin
      ext_s2 <= ext_c;
      ovf_s2 <= ovf_c;
      tag_s2 <= tag_s1;
    end
  end

  assign valid_out    = valid_s2;
  assign extents_out  = ext_s2;
  assign overflow_out = ovf_s2;
  assign tag_out      = tag_s2;

endmodule
